tristate_pad_receiver: RTL and testbench

//  Receive-side companion to the tri-state pad driver. Samples the async pad

---
 rtl/tristate_pad_receiver.sv | 144 ++++++++++++++
 tb/tb_tristate_pad_receiver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/tristate_pad_receiver.sv
// Receive side of the tri-state pad: synchronizes and deglitches the pad sense
// line, blanks the local driver's echo, and flags contention while driving.
module tristate_pad_receiver #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter int unsigned TURNAROUND    = 2,
    parameter bit          IDLE_LEVEL    = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic PAD,
    input  logic I,
    input  logic T,
    input  logic GTS,
    input  logic CLR_CONTEND,
    output logic O,
    output logic RISE,
    output logic FALL,
    output logic BUSY,
    output logic CONTEND
);

    localparam int unsigned CNT_W    = $clog2(FILTER_CYCLES) + 1;
    localparam int unsigned TURN_W   = $clog2(TURNAROUND) + 1;
    localparam int unsigned QUAL_MAX = SYNC_STAGES + 1;
    localparam int unsigned QUAL_W   = $clog2(QUAL_MAX + 1);

    localparam logic [CNT_W-1:0]  FILT_LAST = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURNAROUND - 1);
    localparam logic [QUAL_W-1:0] QUAL_SAT  = QUAL_W'(QUAL_MAX);

    typedef enum logic [1:0] {
        ST_LISTEN = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_TURN   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] i_dly_q, i_dly_d;
    logic [CNT_W-1:0]       filt_cnt_q, filt_cnt_d;
    logic [TURN_W-1:0]      turn_cnt_q, turn_cnt_d;
    logic [QUAL_W-1:0]      qual_q, qual_d;
    logic                   o_q, o_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   contend_q, contend_d;
    logic                   tx_en;
    logic                   sync;
    logic                   i_dly;

    assign tx_en = ~(T | GTS);
    assign sync  = sync_q[SYNC_STAGES-1];
    assign i_dly = i_dly_q[SYNC_STAGES-1];

    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[SYNC_STAGES-2:0], PAD};
        i_dly_d    = {i_dly_q[SYNC_STAGES-2:0], I};
        filt_cnt_d = '0;
        turn_cnt_d = turn_cnt_q;
        qual_d     = '0;
        o_d        = o_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        contend_d  = contend_q;

        case (state_q)
            ST_LISTEN: begin
                if (tx_en) begin
                    state_d = ST_DRIVE;
                end else if (sync != o_q) begin
                    if (filt_cnt_q == FILT_LAST) begin
                        o_d    = sync;
                        rise_d = sync;
                        fall_d = ~sync;
                    end else begin
                        filt_cnt_d = filt_cnt_q + 1'b1;
                    end
                end
            end
            ST_DRIVE: begin
                if (!tx_en) begin
                    state_d    = ST_TURN;
                    turn_cnt_d = TURN_LOAD;
                end
            end
            ST_TURN: begin
                if (tx_en) begin
                    state_d = ST_DRIVE;
                end else if (turn_cnt_q == '0) begin
                    state_d = ST_LISTEN;
                end else begin
                    turn_cnt_d = turn_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_LISTEN;
        endcase

        // Qualify window covers the sync/i_dly pipelines filling after drive starts
        if (state_q == ST_DRIVE) begin
            qual_d = (qual_q == QUAL_SAT) ? qual_q : qual_q + 1'b1;
        end

        if (state_q == ST_DRIVE && qual_q == QUAL_SAT && sync != i_dly) begin
            contend_d = 1'b1;
        end else if (CLR_CONTEND) begin
            contend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_LISTEN;
            sync_q     <= {SYNC_STAGES{IDLE_LEVEL}};
            i_dly_q    <= {SYNC_STAGES{IDLE_LEVEL}};
            filt_cnt_q <= '0;
            turn_cnt_q <= '0;
            qual_q     <= '0;
            o_q        <= IDLE_LEVEL;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            contend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            i_dly_q    <= i_dly_d;
            filt_cnt_q <= filt_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            qual_q     <= qual_d;
            o_q        <= o_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            contend_q  <= contend_d;
        end
    end

    assign O       = o_q;
    assign RISE    = rise_q;
    assign FALL    = fall_q;
    assign BUSY    = (state_q != ST_LISTEN);
    assign CONTEND = contend_q;

endmodule

// File: tb/tb_tristate_pad_receiver.sv
// Directed bench for tristate_pad_receiver with default parameters
// (2 sync stages, 4 filter cycles, 2 turnaround cycles, idle low).
module tb_tristate_pad_receiver;

    logic CLK = 1'b0;
    logic RST, PAD, I, T, GTS, CLR_CONTEND;
    logic O, RISE, FALL, BUSY, CONTEND;

    int n_checks = 0;
    int n_pass   = 0;

    tristate_pad_receiver #(
        .SYNC_STAGES  (2),
        .FILTER_CYCLES(4),
        .TURNAROUND   (2),
        .IDLE_LEVEL   (1'b0)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PAD        (PAD),
        .I          (I),
        .T          (T),
        .GTS        (GTS),
        .CLR_CONTEND(CLR_CONTEND),
        .O          (O),
        .RISE       (RISE),
        .FALL       (FALL),
        .BUSY       (BUSY),
        .CONTEND    (CONTEND)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    // advance one clock and sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; PAD = 1'b0; I = 1'b0; T = 1'b1; GTS = 1'b0; CLR_CONTEND = 1'b0;
        repeat (3) tick();
        check("rst_O", O, 1'b0);
        check("rst_BUSY", BUSY, 1'b0);
        check("rst_CONTEND", CONTEND, 1'b0);
        check("rst_RISE", RISE, 1'b0);
        check("rst_FALL", FALL, 1'b0);
        RST = 1'b0;
        tick();

        // rising step: O changes on the 6th edge after PAD changes
        PAD = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("rise_wait_O", O, 1'b0);
            check("rise_wait_RISE", RISE, 1'b0);
        end
        tick();
        check("rise_O", O, 1'b1);
        check("rise_pulse", RISE, 1'b1);
        tick();
        check("rise_pulse_end", RISE, 1'b0);
        check("rise_O_held", O, 1'b1);

        // falling step
        PAD = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("fall_wait_O", O, 1'b1);
            check("fall_wait_FALL", FALL, 1'b0);
        end
        tick();
        check("fall_O", O, 1'b0);
        check("fall_pulse", FALL, 1'b1);
        tick();
        check("fall_pulse_end", FALL, 1'b0);

        // 3-sample glitch is rejected
        PAD = 1'b1;
        repeat (3) tick();
        PAD = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("glitch_O", O, 1'b0);
            check("glitch_RISE", RISE, 1'b0);
        end

        // drive with pad following I: blanked, no contention
        I = 1'b1; PAD = 1'b1; T = 1'b0;
        tick();
        check("drv_BUSY", BUSY, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("drv_O_frozen", O, 1'b0);
            check("drv_no_contend", CONTEND, 1'b0);
        end
        // release: two turnaround cycles, pad falls while blanked
        T = 1'b1; PAD = 1'b0;
        tick();
        check("turn1_BUSY", BUSY, 1'b1);
        tick();
        check("turn2_BUSY", BUSY, 1'b1);
        tick();
        check("turn_done_BUSY", BUSY, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("post_turn_O", O, 1'b0);
            check("post_turn_RISE", RISE, 1'b0);
        end
        check("post_turn_contend", CONTEND, 1'b0);

        // contention: drive 1, pad held 0
        T = 1'b0;
        tick();
        check("cont_BUSY", BUSY, 1'b1);
        repeat (3) tick();
        check("cont_not_yet", CONTEND, 1'b0);
        tick();
        check("cont_set", CONTEND, 1'b1);
        repeat (3) tick();
        check("cont_held", CONTEND, 1'b1);
        CLR_CONTEND = 1'b1;
        tick();
        check("cont_set_wins", CONTEND, 1'b1);
        CLR_CONTEND = 1'b0;
        T = 1'b1;
        tick();
        check("cont_release", CONTEND, 1'b1);
        CLR_CONTEND = 1'b1;
        tick();
        check("cont_cleared", CONTEND, 1'b0);
        CLR_CONTEND = 1'b0;
        tick();
        check("cont_turn_done", BUSY, 1'b0);

        // GTS forces release mid-drive; pad mismatch after release is ignored
        PAD = 1'b1; T = 1'b0;
        repeat (5) tick();
        check("gts_pre_BUSY", BUSY, 1'b1);
        GTS = 1'b1; PAD = 1'b0;
        tick();
        check("gts_turn1", BUSY, 1'b1);
        tick();
        check("gts_turn2", BUSY, 1'b1);
        tick();
        check("gts_listen", BUSY, 1'b0);
        repeat (4) tick();
        check("gts_no_contend", CONTEND, 1'b0);
        check("gts_O", O, 1'b0);

        // reset in TURN returns to LISTEN
        GTS = 1'b0;
        tick();
        T = 1'b1;
        tick();
        check("rst_turn_pre", BUSY, 1'b1);
        RST = 1'b1;
        tick();
        check("rst_turn_BUSY", BUSY, 1'b0);
        RST = 1'b0;
        tick();
        check("rst_turn_stays", BUSY, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
